// File: rtl/led_output_arbiter.sv
// led_output_arbiter: round-robin time-sharing of the user LEDs between status sources.
// Optional feature macro LED_ARB_URGENT_EN: requester 0 wins every arbitration and preempts other owners.
module led_output_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int LED_W       = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*LED_W-1:0]   req_pattern,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [LED_W-1:0]           led_out,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [LED_W-1:0] BLANK = (ACTIVE_LOW != 0) ? {LED_W{1'b1}} : {LED_W{1'b0}};

  typedef enum logic {IDLE, SHOW} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   hold_cnt, hold_n;
  logic [IDX_W-1:0]   rr_ptr, rr_n;
  logic [IDX_W-1:0]   owner_n;
  logic               busy_n;
  logic [LED_W-1:0]   led_n;

  logic               arb_instant;
  logic               urgent_grant;
  logic               do_grant;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   grant_idx;
  logic [LED_W-1:0]   sel_pattern;

  assign arb_instant = (state == IDLE) || (hold_cnt == CNT_W'(HOLD_CYCLES - 1));

  // Search from the requester after rr_ptr, wrapping explicitly at NUM_REQ-1.
  always_comb begin
    logic [IDX_W:0] cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ))
        cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!rr_found && req_valid[cand[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[IDX_W-1:0];
      end
    end
  end

`ifdef LED_ARB_URGENT_EN
  // Requester 0 wins any arbitration and preempts a different owner mid-hold.
  assign urgent_grant = req_valid[0] && (arb_instant || (state == SHOW && owner != '0));
`else
  assign urgent_grant = 1'b0;
`endif

  assign do_grant  = urgent_grant || (arb_instant && rr_found);
  assign grant_idx = urgent_grant ? '0 : rr_idx;
  assign req_ready = (do_grant && !reset) ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    sel_pattern = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_idx == IDX_W'(i))
        sel_pattern = req_pattern[i*LED_W +: LED_W];
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    rr_n    = rr_ptr;
    owner_n = owner;
    busy_n  = busy;
    led_n   = led_out;
    if (do_grant) begin
      state_n = SHOW;
      hold_n  = '0;
      owner_n = grant_idx;
      busy_n  = 1'b1;
      led_n   = (ACTIVE_LOW != 0) ? ~sel_pattern : sel_pattern;
      if (!urgent_grant)
        rr_n = grant_idx;
    end else if (arb_instant) begin
      state_n = IDLE;
      hold_n  = '0;
      busy_n  = 1'b0;
      led_n   = BLANK;
    end else if (state == SHOW) begin
      hold_n = hold_cnt + CNT_W'(1);
    end
  end

  // rr_ptr resets to the last index so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      owner    <= '0;
      busy     <= 1'b0;
      led_out  <= BLANK;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      rr_ptr   <= rr_n;
      owner    <= owner_n;
      busy     <= busy_n;
      led_out  <= led_n;
    end
  end

endmodule

// File: tb/tb_led_output_arbiter.sv
// Scoreboard bench for led_output_arbiter (NUM_REQ=3, LED_W=4, HOLD_CYCLES=4, ACTIVE_LOW=1).
// Expectations are pushed as each cycle's stimulus is driven and popped at the following falling edge.
module tb_led_output_arbiter;

  localparam int NUM_REQ     = 3;
  localparam int LED_W       = 4;
  localparam int HOLD_CYCLES = 4;
  localparam int ACTIVE_LOW  = 1;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [11:0] req_pattern;
  logic [2:0]  req_ready;
  logic [3:0]  led_out;
  logic [1:0]  owner;
  logic        busy;

  logic [9:0]  exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  led_output_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .LED_W      (LED_W),
    .HOLD_CYCLES(HOLD_CYCLES),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_pattern(req_pattern),
    .req_ready  (req_ready),
    .led_out    (led_out),
    .owner      (owner),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of run, want finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [9:0] pack(input logic [2:0] r, input logic [3:0] l,
                                      input logic b, input logic [1:0] o);
    return {r, l, b, o};
  endfunction

  task automatic drive(input logic [2:0] v, input logic [11:0] p);
    @(posedge clk);
    #1;
    req_valid   = v;
    req_pattern = p;
  endtask

  task automatic do_reset;
    reset       = 1'b1;
    req_valid   = '0;
    req_pattern = '0;
    #2;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [9:0] got, want;
    reset       = 1'b1;
    req_valid   = 3'b111;
    req_pattern = 12'h421;
    for (int t = 0; t < 3; t++) begin
      exp_q.push_back(pack(3'b000, 4'hF, 1'b0, 2'd0));
      if (t == 0) #3;
      else @(negedge clk);
      got  = pack(req_ready, led_out, busy, owner);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL reset t=%0d: got ready=%b led=%h busy=%b owner=%0d, want ready=%b led=%h busy=%b owner=%0d",
                 t, got[9:7], got[6:3], got[2], got[1:0], want[9:7], want[6:3], want[2], want[1:0]);
      end
    end
    req_valid = '0;
    reset     = 1'b0;
  endtask

  task automatic test_single;
    logic [9:0] got, want;
    do_reset();
    for (int t = 0; t <= 5; t++) begin
      drive(t == 0 ? 3'b010 : 3'b000, 12'h0A0);
      if (t == 0)      exp_q.push_back(pack(3'b010, 4'hF, 1'b0, 2'd0));
      else if (t <= 4) exp_q.push_back(pack(3'b000, 4'h5, 1'b1, 2'd1));
      else             exp_q.push_back(pack(3'b000, 4'hF, 1'b0, 2'd0));
      @(negedge clk);
      got  = pack(req_ready, led_out, busy, busy ? owner : 2'd0);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL single t=%0d: got ready=%b led=%h busy=%b owner=%0d, want ready=%b led=%h busy=%b owner=%0d",
                 t, got[9:7], got[6:3], got[2], got[1:0], want[9:7], want[6:3], want[2], want[1:0]);
      end
    end
  endtask

  // Patterns 1,2,4 make the expected LED drive ~(1 << owner).
  task automatic test_round_robin;
    logic [9:0] got, want;
    int gi, go;
    do_reset();
    for (int t = 0; t <= 20; t++) begin
      drive(3'b111, 12'h421);
`ifdef LED_ARB_URGENT_EN
      gi = 0;
      go = 0;
`else
      gi = (t / 4) % 3;
      go = ((t - 1) / 4) % 3;
`endif
      exp_q.push_back(pack((t % 4 == 0) ? 3'(3'b001 << gi) : 3'b000,
                           (t == 0) ? 4'hF : ~4'(4'b0001 << go),
                           t != 0,
                           (t == 0) ? 2'd0 : 2'(go)));
      @(negedge clk);
      got  = pack(req_ready, led_out, busy, busy ? owner : 2'd0);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL round_robin t=%0d: got ready=%b led=%h busy=%b owner=%0d, want ready=%b led=%h busy=%b owner=%0d",
                 t, got[9:7], got[6:3], got[2], got[1:0], want[9:7], want[6:3], want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] got, want;
    do_reset();
    for (int t = 0; t <= 9; t++) begin
      drive((t == 0 || t == 4) ? 3'b100 : 3'b000, (t < 4) ? 12'h100 : 12'h600);
      if (t == 0)      exp_q.push_back(pack(3'b100, 4'hF, 1'b0, 2'd0));
      else if (t < 4)  exp_q.push_back(pack(3'b000, 4'hE, 1'b1, 2'd2));
      else if (t == 4) exp_q.push_back(pack(3'b100, 4'hE, 1'b1, 2'd2));
      else if (t <= 8) exp_q.push_back(pack(3'b000, 4'h9, 1'b1, 2'd2));
      else             exp_q.push_back(pack(3'b000, 4'hF, 1'b0, 2'd0));
      @(negedge clk);
      got  = pack(req_ready, led_out, busy, busy ? owner : 2'd0);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL back_to_back t=%0d: got ready=%b led=%h busy=%b owner=%0d, want ready=%b led=%h busy=%b owner=%0d",
                 t, got[9:7], got[6:3], got[2], got[1:0], want[9:7], want[6:3], want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_withdrawn;
    logic [9:0] got, want;
    logic [2:0] v;
    do_reset();
    for (int t = 0; t <= 9; t++) begin
      v = (t == 0) ? 3'b001 : (t == 2) ? 3'b010 : (t == 4) ? 3'b100 : 3'b000;
      drive(v, 12'h357);
      if (t == 0)      exp_q.push_back(pack(3'b001, 4'hF, 1'b0, 2'd0));
      else if (t < 4)  exp_q.push_back(pack(3'b000, 4'h8, 1'b1, 2'd0));
      else if (t == 4) exp_q.push_back(pack(3'b100, 4'h8, 1'b1, 2'd0));
      else if (t <= 8) exp_q.push_back(pack(3'b000, 4'hC, 1'b1, 2'd2));
      else             exp_q.push_back(pack(3'b000, 4'hF, 1'b0, 2'd0));
      @(negedge clk);
      got  = pack(req_ready, led_out, busy, busy ? owner : 2'd0);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL withdrawn t=%0d: got ready=%b led=%h busy=%b owner=%0d, want ready=%b led=%h busy=%b owner=%0d",
                 t, got[9:7], got[6:3], got[2], got[1:0], want[9:7], want[6:3], want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_urgent;
    logic [9:0] got, want;
    logic [2:0] v;
    do_reset();
`ifdef LED_ARB_URGENT_EN
    for (int t = 0; t <= 7; t++) begin
      v = (t == 0) ? 3'b010 : (t == 2) ? 3'b001 : 3'b000;
      drive(v, 12'h0A3);
      if (t == 0)      exp_q.push_back(pack(3'b010, 4'hF, 1'b0, 2'd0));
      else if (t == 1) exp_q.push_back(pack(3'b000, 4'h5, 1'b1, 2'd1));
      else if (t == 2) exp_q.push_back(pack(3'b001, 4'h5, 1'b1, 2'd1));
      else if (t <= 6) exp_q.push_back(pack(3'b000, 4'hC, 1'b1, 2'd0));
      else             exp_q.push_back(pack(3'b000, 4'hF, 1'b0, 2'd0));
`else
    for (int t = 0; t <= 9; t++) begin
      v = (t == 0) ? 3'b010 : (t >= 2 && t <= 4) ? 3'b001 : 3'b000;
      drive(v, 12'h0A3);
      if (t == 0)      exp_q.push_back(pack(3'b010, 4'hF, 1'b0, 2'd0));
      else if (t < 4)  exp_q.push_back(pack(3'b000, 4'h5, 1'b1, 2'd1));
      else if (t == 4) exp_q.push_back(pack(3'b001, 4'h5, 1'b1, 2'd1));
      else if (t <= 8) exp_q.push_back(pack(3'b000, 4'hC, 1'b1, 2'd0));
      else             exp_q.push_back(pack(3'b000, 4'hF, 1'b0, 2'd0));
`endif
      @(negedge clk);
      got  = pack(req_ready, led_out, busy, busy ? owner : 2'd0);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL urgent t=%0d: got ready=%b led=%h busy=%b owner=%0d, want ready=%b led=%h busy=%b owner=%0d",
                 t, got[9:7], got[6:3], got[2], got[1:0], want[9:7], want[6:3], want[2], want[1:0]);
      end
    end
  endtask

  // Reset lands between clock edges while requester 0 owns the LEDs, so rr_ptr was 0 beforehand.
  task automatic test_async_reset;
    logic [9:0] got, want;
    do_reset();
    for (int t = 0; t <= 1; t++) begin
      drive(t == 0 ? 3'b001 : 3'b000, 12'h007);
      exp_q.push_back(t == 0 ? pack(3'b001, 4'hF, 1'b0, 2'd0) : pack(3'b000, 4'h8, 1'b1, 2'd0));
      @(negedge clk);
      got  = pack(req_ready, led_out, busy, busy ? owner : 2'd0);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL async_pre t=%0d: got ready=%b led=%h busy=%b owner=%0d, want ready=%b led=%h busy=%b owner=%0d",
                 t, got[9:7], got[6:3], got[2], got[1:0], want[9:7], want[6:3], want[2], want[1:0]);
      end
    end
    #1;
    req_valid   = 3'b101;
    req_pattern = 12'h603;
    reset       = 1'b1;
    exp_q.push_back(pack(3'b000, 4'hF, 1'b0, 2'd0));
    #1;
    got  = pack(req_ready, led_out, busy, owner);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL async_immediate: got ready=%b led=%h busy=%b owner=%0d, want ready=%b led=%h busy=%b owner=%0d",
               got[9:7], got[6:3], got[2], got[1:0], want[9:7], want[6:3], want[2], want[1:0]);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 3'b000;
    for (int t = 0; t <= 2; t++) begin
      drive(t == 1 ? 3'b101 : 3'b000, 12'h603);
      if (t == 0)      exp_q.push_back(pack(3'b000, 4'hF, 1'b0, 2'd0));
      else if (t == 1) exp_q.push_back(pack(3'b001, 4'hF, 1'b0, 2'd0));
      else             exp_q.push_back(pack(3'b000, 4'hC, 1'b1, 2'd0));
      @(negedge clk);
      got  = pack(req_ready, led_out, busy, busy ? owner : 2'd0);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL async_post t=%0d: got ready=%b led=%h busy=%b owner=%0d, want ready=%b led=%h busy=%b owner=%0d",
                 t, got[9:7], got[6:3], got[2], got[1:0], want[9:7], want[6:3], want[2], want[1:0]);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_pattern = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_withdrawn();
    test_urgent();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
